serial_word_collector: RTL and testbench

//  Consumes the registered serial bit stream produced by the dff stage (its q output) and assembles it into WIDTH-bit words.
//  - Completed words are presented on a valid/ready output port.
//  - A one-word holding register lets collection of the next word proceed while the previous word waits.
//  - Sits directly downstream of the dff, on the same clock, ahead of any word-wide consumer.

---
 rtl/serial_word_collector_pkg.sv | 23 ++
 rtl/serial_word_collector_if.sv | 38 +++
 rtl/serial_word_collector_bit_shift_cell.sv | 35 +++
 rtl/serial_word_collector.sv | 128 ++++++++++++
 tb/tb_serial_word_collector.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/serial_word_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Types and helpers shared by the serial word collector files.
//                - out_state_t : output-stage state (EMPTY / FULL).
//                - clog2w()    : width of the bit counter for a given WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // A 1-bit counter is still needed for WIDTH=2, and a zero-width vector must
    // never be produced, so small widths are clamped to 1.
    function automatic int clog2w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_collector_if
//  Description : Serial-in / word-out bus of the serial word collector.
//                master : serial source and word consumer (drives sin, sin_en,
//                         word_ready, clr_ovr)
//                slave  : the collector (drives word_out, word_valid,
//                         bit_cnt, overrun)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_word_collector_if #(
    parameter int WIDTH = 8
);
    import serial_pkg::*;

    localparam int c_CNT_W = clog2w(WIDTH);

    logic               sin;
    logic               sin_en;
    logic               word_ready;
    logic               clr_ovr;
    logic [WIDTH-1:0]   word_out;
    logic               word_valid;
    logic [c_CNT_W-1:0] bit_cnt;
    logic               overrun;

    modport master (
        output sin, sin_en, word_ready, clr_ovr,
        input  word_out, word_valid, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_en, word_ready, clr_ovr,
        output word_out, word_valid, bit_cnt, overrun
    );

endinterface
`default_nettype wire

// File: rtl/serial_word_collector_bit_shift_cell.sv
`default_nettype none
// ============================================================================
//  Module      : bit_shift_cell
//  Description : One stage of the collector shift register: a 1-bit rising-
//                edge register with load enable and asynchronous active-high
//                reset.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset (clears o_q)
//                i_en - load enable
//                i_d  - data in
//                o_q  - registered data out
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_shift_cell (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_en,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_collector
//  Description : Assembles a registered serial bit stream into WIDTH-bit words
//                and presents them through a one-word valid/ready holding
//                register. Collection never stalls; a completed word that
//                cannot be stored is dropped and flagged by sticky overrun.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - slave side of serial_word_collector_if:
//                       sin/sin_en    serial bit and its qualifier
//                       word_out      assembled word (stable while valid)
//                       word_valid    word_out holds an unconsumed word
//                       word_ready    consumer accepts word_out
//                       bit_cnt       bits collected toward current word
//                       overrun       sticky dropped-word flag
//                       clr_ovr       synchronous clear of overrun
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_word_collector_if.slave  bus
);

    localparam int c_CNT_W = clog2w(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

    logic               w_sin;
    logic [WIDTH-1:0]   w_shift_q;
    logic [WIDTH-1:0]   w_shift_d;
    logic               w_complete;
    logic               w_ovr_set;

    logic [c_CNT_W-1:0] r_bit_cnt;
    out_state_t         r_state;
    logic [WIDTH-1:0]   r_word_out;
    logic               r_word_valid;
    logic               r_overrun;

    // Only a definite 1 counts as 1; X or Z on the serial input becomes 0.
    assign w_sin = (bus.sin === 1'b1);

    // Next shift-register value. On the completing bit this is also the full
    // word, so the output stage loads it directly.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_d = {w_shift_q[WIDTH-2:0], w_sin};
        end else begin : g_lsb_first
            assign w_shift_d = {w_sin, w_shift_q[WIDTH-1:1]};
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_cell
            bit_shift_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .i_en (bus.sin_en),
                .i_d  (w_shift_d[gi]),
                .o_q  (w_shift_q[gi])
            );
        end
    endgenerate

    assign w_complete = bus.sin_en && (r_bit_cnt == c_LAST_CNT);

    // A word is dropped only when the holding register is occupied and the
    // consumer is not taking it on the same edge.
    assign w_ovr_set  = (r_state == FULL) && w_complete && !bus.word_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
        end else if (bus.sin_en) begin
            r_bit_cnt <= (r_bit_cnt == c_LAST_CNT) ? '0 : r_bit_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_complete) begin
                        r_state      <= FULL;
                        r_word_out   <= w_shift_d;
                        r_word_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (w_complete) begin
                        // Accepted-and-reloaded: stay FULL with the new word.
                        if (bus.word_ready) begin
                            r_word_out <= w_shift_d;
                        end
                    end else if (bus.word_ready) begin
                        r_state      <= EMPTY;
                        r_word_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= EMPTY;
                    r_word_valid <= 1'b0;
                end
            endcase

            // Set has priority over a same-cycle clear.
            r_overrun <= w_ovr_set | (r_overrun & ~bus.clr_ovr);
        end
    end

    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_collector
//  Description : Directed self-checking bench for serial_word_collector.
//                Instance A is MSB-first, instance B is LSB-first, both
//                WIDTH=8. Inputs change 1 time unit after the rising edge and
//                outputs are checked at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_collector;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_word_collector_if #(.WIDTH(WIDTH)) bus_a ();
    serial_word_collector_if #(.WIDTH(WIDTH)) bus_b ();

    serial_word_collector #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    serial_word_collector #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit_a(input logic b);
        bus_a.sin    = b;
        bus_a.sin_en = 1'b1;
        tick();
        bus_a.sin_en = 1'b0;
        bus_a.sin    = 1'b0;
    endtask

    // MSB of w goes first. ready_last / clr_last raise word_ready / clr_ovr
    // only on the completing bit and drop them afterwards.
    task automatic send_word_a(input logic [7:0] w, input bit ready_last, input bit clr_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                if (ready_last) bus_a.word_ready = 1'b1;
                if (clr_last)   bus_a.clr_ovr    = 1'b1;
            end
            send_bit_a(w[i]);
        end
        if (ready_last) bus_a.word_ready = 1'b0;
        if (clr_last)   bus_a.clr_ovr    = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] v3c;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_a.sin = 1'b0; bus_a.sin_en = 1'b0; bus_a.word_ready = 1'b0; bus_a.clr_ovr = 1'b0;
        bus_b.sin = 1'b0; bus_b.sin_en = 1'b0; bus_b.word_ready = 1'b0; bus_b.clr_ovr = 1'b0;
        #2;
        check("reset_valid",   32'(bus_a.word_valid), 32'd0);
        check("reset_overrun", 32'(bus_a.overrun),    32'd0);
        check("reset_bitcnt",  32'(bus_a.bit_cnt),    32'd0);
        check("reset_word",    32'(bus_a.word_out),   32'd0);
        tick();
        rst = 1'b0;

        // Basic word, MSB first, consumer always ready.
        bus_a.word_ready = 1'b1;
        send_bit_a(1'b1); send_bit_a(1'b0); send_bit_a(1'b1);
        check("basic_bitcnt3", 32'(bus_a.bit_cnt), 32'd3);
        check("basic_valid_early", 32'(bus_a.word_valid), 32'd0);
        send_bit_a(1'b0); send_bit_a(1'b0); send_bit_a(1'b1); send_bit_a(1'b0); send_bit_a(1'b1);
        check("basic_valid", 32'(bus_a.word_valid), 32'd1);
        check("basic_word",  32'(bus_a.word_out),   32'hA5);
        check("basic_bitcnt_wrap", 32'(bus_a.bit_cnt), 32'd0);
        tick();
        check("basic_valid_drop", 32'(bus_a.word_valid), 32'd0);
        check("basic_word_hold",  32'(bus_a.word_out),   32'hA5);

        // Gapped enable: 5 idle cycles after the third bit.
        send_bit_a(1'b1); send_bit_a(1'b0); send_bit_a(1'b1);
        for (int g = 0; g < 5; g++) begin
            tick();
            check("gap_bitcnt", 32'(bus_a.bit_cnt), 32'd3);
        end
        send_bit_a(1'b0); send_bit_a(1'b0); send_bit_a(1'b1); send_bit_a(1'b0); send_bit_a(1'b1);
        check("gap_valid", 32'(bus_a.word_valid), 32'd1);
        check("gap_word",  32'(bus_a.word_out),   32'hA5);
        tick();
        check("gap_drain", 32'(bus_a.word_valid), 32'd0);
        bus_a.word_ready = 1'b0;

        // LSB first on instance B: bits 1,0,1,0,0,1,0,1 -> 8'hA5.
        pat = 8'b1010_0101;
        bus_b.word_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bus_b.sin    = pat[i];
            bus_b.sin_en = 1'b1;
            tick();
        end
        bus_b.sin_en = 1'b0;
        bus_b.sin    = 1'b0;
        check("lsb_valid", 32'(bus_b.word_valid), 32'd1);
        check("lsb_word",  32'(bus_b.word_out),   32'hA5);
        bus_b.word_ready = 1'b0;

        // Back-pressure. First bit of 8'h3C is a 0 sent as X.
        v3c = 8'h3C;
        send_bit_a(1'bx);
        for (int i = 6; i >= 0; i--) send_bit_a(v3c[i]);
        check("bp_valid",   32'(bus_a.word_valid), 32'd1);
        check("bp_word",    32'(bus_a.word_out),   32'h3C);
        check("bp_ovr_pre", 32'(bus_a.overrun),    32'd0);
        send_word_a(8'hC3, 1'b0, 1'b0);
        check("ovr_word_kept", 32'(bus_a.word_out),   32'h3C);
        check("ovr_set",       32'(bus_a.overrun),    32'd1);
        check("ovr_valid",     32'(bus_a.word_valid), 32'd1);
        send_word_a(8'hF0, 1'b0, 1'b1);
        check("ovr_set_beats_clr", 32'(bus_a.overrun),  32'd1);
        check("ovr_word_kept2",    32'(bus_a.word_out), 32'h3C);
        bus_a.clr_ovr = 1'b1;
        tick();
        bus_a.clr_ovr = 1'b0;
        check("ovr_clear", 32'(bus_a.overrun), 32'd0);

        // Simultaneous accept and complete.
        bus_a.word_ready = 1'b1;
        tick();
        bus_a.word_ready = 1'b0;
        check("sim_empty", 32'(bus_a.word_valid), 32'd0);
        send_word_a(8'h11, 1'b0, 1'b0);
        check("sim_hold11", 32'(bus_a.word_out), 32'h11);
        send_word_a(8'h22, 1'b1, 1'b0);
        check("sim_valid",   32'(bus_a.word_valid), 32'd1);
        check("sim_word22",  32'(bus_a.word_out),   32'h22);
        check("sim_overrun", 32'(bus_a.overrun),    32'd0);

        // Reset mid-word with valid and overrun both set.
        send_word_a(8'hFF, 1'b0, 1'b0);
        check("mid_ovr_pre", 32'(bus_a.overrun), 32'd1);
        send_bit_a(1'b1); send_bit_a(1'b1); send_bit_a(1'b1);
        check("mid_bitcnt_pre", 32'(bus_a.bit_cnt), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",   32'(bus_a.word_valid), 32'd0);
        check("mid_rst_overrun", 32'(bus_a.overrun),    32'd0);
        check("mid_rst_bitcnt",  32'(bus_a.bit_cnt),    32'd0);
        check("mid_rst_word",    32'(bus_a.word_out),   32'd0);
        tick();
        check("mid_rst_hold", 32'(bus_a.word_valid), 32'd0);
        rst = 1'b0;
        bus_a.word_ready = 1'b1;
        send_word_a(8'h5A, 1'b0, 1'b0);
        check("post_rst_valid", 32'(bus_a.word_valid), 32'd1);
        check("post_rst_word",  32'(bus_a.word_out),   32'h5A);
        bus_a.word_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
